// File: rtl/cpu_pkg.sv
// Shared sequencer state encoding and opcode constants for the core's control units.
package cpu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExecute,
      StMemory,
      StWriteback,
      StHalt
   } seq_state_t;

   localparam logic [7:0] HALT_OP = 8'hFF;

endpackage

// File: rtl/program_counter.sv
// Program counter register: clear, increment or load a jump target; wraps modulo 2^PC_W.
module program_counter #(
   parameter int unsigned PC_W = 10
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_clear,
   input  logic            i_advance,
   input  logic            i_jump,
   input  logic [PC_W-1:0] i_jump_target,
   output logic [PC_W-1:0] o_pc
);

   logic [PC_W-1:0] r_pc;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pc <= '0;
      end else if (i_clear) begin
         r_pc <= '0;
      end else if (i_advance) begin
         // Increment overflow drops out of the PC_W-bit result, giving the wrap.
         r_pc <= i_jump ? i_jump_target : r_pc + PC_W'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with PC and
// saturating retire/busy-cycle counters.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [7:0]       i_opcode,
   input  logic             i_jump,
   input  logic             i_mem_read,
   input  logic             i_mem_write,
   input  logic             i_reg_write,
   input  logic [PC_W-1:0]  i_jump_target,
   input  logic             i_mem_ready,
   output logic [PC_W-1:0]  o_pc,
   output logic             o_ir_load,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic             o_rf_we,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_instr_count,
   output logic [CNT_W-1:0] o_cycle_count
);

   seq_state_t       r_state;
   seq_state_t       w_state_d;
   logic             w_clear;
   logic             w_retire;
   logic             w_busy;
   logic [CNT_W-1:0] r_instr_count;
   logic [CNT_W-1:0] r_cycle_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_clear   = 1'b0;
      w_retire  = 1'b0;
      unique case (r_state)
         StIdle, StHalt: begin
            if (i_start) begin
               w_state_d = StFetch;
               w_clear   = 1'b1;
            end
         end
         StFetch: w_state_d = StDecode;
         StDecode: w_state_d = (i_opcode == HALT_OP) ? StHalt : StExecute;
         StExecute: begin
            if (i_mem_read || i_mem_write) begin
               w_state_d = StMemory;
            end else if (i_reg_write) begin
               w_state_d = StWriteback;
            end else begin
               w_state_d = StFetch;
               w_retire  = 1'b1;
            end
         end
         StMemory: begin
            // A write wins over a simultaneous read: treated as a store.
            if (i_mem_ready) begin
               if (i_mem_write) begin
                  w_state_d = StFetch;
                  w_retire  = 1'b1;
               end else begin
                  w_state_d = StWriteback;
               end
            end
         end
         StWriteback: begin
            w_state_d = StFetch;
            w_retire  = 1'b1;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign w_busy = (r_state != StIdle) && (r_state != StHalt);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_instr_count <= '0;
         r_cycle_count <= '0;
      end else if (w_clear) begin
         r_instr_count <= '0;
         r_cycle_count <= '0;
      end else begin
         if (w_retire && (r_instr_count != '1)) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
         end
         if (w_busy && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
         end
      end
   end

   program_counter #(
      .PC_W (PC_W)
   ) u_program_counter (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_clear       (w_clear),
      .i_advance     (w_retire),
      .i_jump        (i_jump),
      .i_jump_target (i_jump_target),
      .o_pc          (o_pc)
   );

   assign o_ir_load     = (r_state == StFetch);
   assign o_mem_req     = (r_state == StMemory);
   assign o_mem_we      = (r_state == StMemory) && i_mem_write;
   assign o_rf_we       = (r_state == StWriteback);
   assign o_busy        = w_busy;
   assign o_done        = (r_state == StHalt);
   assign o_instr_count = r_instr_count;
   assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  opcode;
   logic        jump;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic [9:0]  jump_target;
   logic        mem_ready;
   logic [9:0]  pc;
   logic        ir_load;
   logic        mem_req;
   logic        mem_we;
   logic        rf_we;
   logic        busy;
   logic        done;
   logic [15:0] instr_count;
   logic [15:0] cycle_count;

   int n_vec = 0;
   int n_err = 0;

   instr_sequencer #(
      .PC_W  (10),
      .CNT_W (16)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_opcode      (opcode),
      .i_jump        (jump),
      .i_mem_read    (mem_read),
      .i_mem_write   (mem_write),
      .i_reg_write   (reg_write),
      .i_jump_target (jump_target),
      .i_mem_ready   (mem_ready),
      .o_pc          (pc),
      .o_ir_load     (ir_load),
      .o_mem_req     (mem_req),
      .o_mem_we      (mem_we),
      .o_rf_we       (rf_we),
      .o_busy        (busy),
      .o_done        (done),
      .o_instr_count (instr_count),
      .o_cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ctl(input logic [7:0] op, input logic j, input logic mr, input logic mw,
                          input logic rw, input logic [9:0] tgt);
      opcode      = op;
      jump        = j;
      mem_read    = mr;
      mem_write   = mw;
      reg_write   = rw;
      jump_target = tgt;
   endtask

   // Starts at a FETCH cycle; runs to the next FETCH, answering memory after `delay` wait cycles.
   task automatic run_instr(input string tag, input int delay, input int exp_cyc,
                            input int exp_req, input int exp_we, input int exp_rfwe,
                            input logic [9:0] exp_pc);
      int cyc  = 0;
      int req  = 0;
      int we   = 0;
      int rfwe = 0;
      mem_ready = 1'b0;
      do begin
         tick();
         cyc++;
         if (mem_req) begin
            req++;
            if (mem_we) we++;
            mem_ready = (req > delay);
         end else begin
            mem_ready = 1'b0;
         end
         if (rf_we) rfwe++;
      end while (!ir_load && !done && cyc < 40);
      mem_ready = 1'b0;
      chk({tag, " reached_fetch"}, 32'(ir_load), 32'd1);
      chk({tag, " fetch_to_fetch"}, cyc, exp_cyc);
      chk({tag, " mem_req_cycles"}, req, exp_req);
      chk({tag, " mem_we_cycles"}, we, exp_we);
      chk({tag, " rf_we_cycles"}, rfwe, exp_rfwe);
      chk({tag, " pc"}, 32'(pc), 32'(exp_pc));
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      mem_ready = 1'b0;
      set_ctl(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
      tick();
      tick();
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset pc", 32'(pc), 0);
      chk("reset mem_req", 32'(mem_req), 0);
      chk("reset ir_load", 32'(ir_load), 0);
      chk("reset instr_count", 32'(instr_count), 0);
      chk("reset cycle_count", 32'(cycle_count), 0);
      reset = 1'b0;
      tick();
      chk("idle holds", 32'(busy), 0);

      // Three ALU ops with writeback, then HALT.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start fetch", 32'(ir_load), 1);
      chk("start pc", 32'(pc), 0);
      set_ctl(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
      run_instr("alu_wr0", 0, 4, 0, 0, 1, 10'd1);
      run_instr("alu_wr1", 0, 4, 0, 0, 1, 10'd2);
      run_instr("alu_wr2", 0, 4, 0, 0, 1, 10'd3);
      set_ctl(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
      tick();
      tick();
      chk("halt done", 32'(done), 1);
      chk("halt busy", 32'(busy), 0);
      chk("halt pc", 32'(pc), 3);
      chk("halt instr_count", 32'(instr_count), 3);
      chk("halt cycle_count", 32'(cycle_count), 14);
      tick();
      chk("halt hold pc", 32'(pc), 3);
      chk("halt hold cycle_count", 32'(cycle_count), 14);

      // Restart from HALT.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart fetch", 32'(ir_load), 1);
      chk("restart done", 32'(done), 0);
      chk("restart pc", 32'(pc), 0);
      chk("restart instr_count", 32'(instr_count), 0);
      chk("restart cycle_count", 32'(cycle_count), 0);

      set_ctl(8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
      run_instr("load_wait3", 3, 8, 4, 0, 1, 10'd1);
      set_ctl(8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000);
      run_instr("store_now", 0, 4, 1, 1, 0, 10'd2);
      set_ctl(8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 10'h000);
      run_instr("rd_wr_store", 1, 5, 2, 2, 0, 10'd3);
      set_ctl(8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 10'h155);
      run_instr("jump_155", 0, 3, 0, 0, 0, 10'h155);
      set_ctl(8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
      run_instr("jump_3ff", 0, 3, 0, 0, 0, 10'h3FF);
      set_ctl(8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 10'h155);
      run_instr("wrap", 0, 3, 0, 0, 0, 10'h000);
      chk("mid instr_count", 32'(instr_count), 6);
      chk("mid cycle_count", 32'(cycle_count), 26);

      // start during EXECUTE must be ignored.
      set_ctl(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy start rf_we", 32'(rf_we), 1);
      chk("busy start pc", 32'(pc), 0);
      chk("busy start instr_count", 32'(instr_count), 6);
      tick();
      chk("busy start fetch", 32'(ir_load), 1);
      chk("busy start pc after", 32'(pc), 1);
      chk("busy start instr_count after", 32'(instr_count), 7);
      chk("busy start cycle_count", 32'(cycle_count), 30);

      // Asynchronous reset while in MEMORY.
      set_ctl(8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
      mem_ready = 1'b0;
      tick();
      tick();
      tick();
      chk("pre-reset mem_req", 32'(mem_req), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset mem_req", 32'(mem_req), 0);
      chk("async reset busy", 32'(busy), 0);
      chk("async reset pc", 32'(pc), 0);
      chk("async reset instr_count", 32'(instr_count), 0);
      chk("async reset cycle_count", 32'(cycle_count), 0);
      tick();
      reset = 1'b0;
      tick();
      chk("post reset busy", 32'(busy), 0);
      chk("post reset ir_load", 32'(ir_load), 0);
      chk("post reset pc", 32'(pc), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
